// File: rtl/mult_seq_ctrl_if.sv
// Handshake bundle between the synchronised front-panel requests, the sequencing
// controller and the accumulator/register unit of the add-shift multiplier.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic          LoadA;
    logic          LoadB;
    logic          Execute;
    logic          M;
    logic          Ld_A;
    logic          Ld_B;
    logic          Clr_XA;
    logic          Add_En;
    logic          Sub_En;
    logic          Shift_En;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] Count;

    modport master (
        output LoadA, LoadB, Execute, M,
        input  Ld_A, Ld_B, Clr_XA, Add_En, Sub_En, Shift_En, Busy, Done, Count
    );

    modport slave (
        input  LoadA, LoadB, Execute, M,
        output Ld_A, Ld_B, Clr_XA, Add_En, Sub_En, Shift_En, Busy, Done, Count
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// WIDTH-iteration add/shift/subtract sequencer for the signed add-shift multiplier.
// Define MULT_SEQ_SKIP_ADD_EN to fold M = 0 iterations into a single shift cycle.
module mult_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input logic            Clk,
    input logic            Reset,
    mult_seq_ctrl_if.slave ctrl
);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StAdd,
        StShift,
        StDone
    } state_e;

    localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);
    localparam logic [CW-1:0] Full     = CW'(WIDTH);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] countInc;
    logic          lastShift;
    logic          signIter;

    assign countInc   = count_q + 1'b1;
    assign lastShift  = (countInc == Full);
    assign signIter   = (count_q == LastIter);
    assign ctrl.Count = count_q;

    // The final iteration weighs the multiplier sign bit, so it subtracts instead of adding.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        ctrl.Ld_A     = 1'b0;
        ctrl.Ld_B     = 1'b0;
        ctrl.Clr_XA   = 1'b0;
        ctrl.Add_En   = 1'b0;
        ctrl.Sub_En   = 1'b0;
        ctrl.Shift_En = 1'b0;
        ctrl.Busy     = 1'b0;
        ctrl.Done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                ctrl.Ld_A = ctrl.LoadA;
                ctrl.Ld_B = ctrl.LoadB;
                if (ctrl.Execute) state_d = StClr;
            end
            StClr: begin
                ctrl.Clr_XA = 1'b1;
                ctrl.Busy   = 1'b1;
                count_d     = '0;
                state_d     = StAdd;
            end
            StAdd: begin
                ctrl.Busy = 1'b1;
`ifdef MULT_SEQ_SKIP_ADD_EN
                if (!ctrl.M) begin
                    ctrl.Shift_En = 1'b1;
                    count_d       = countInc;
                    state_d       = lastShift ? StDone : StAdd;
                end else begin
                    ctrl.Add_En = ~signIter;
                    ctrl.Sub_En = signIter;
                    state_d     = StShift;
                end
`else
                ctrl.Add_En = ctrl.M & ~signIter;
                ctrl.Sub_En = ctrl.M & signIter;
                state_d     = StShift;
`endif
            end
            StShift: begin
                ctrl.Busy     = 1'b1;
                ctrl.Shift_En = 1'b1;
                count_d       = countInc;
                state_d       = lastShift ? StDone : StAdd;
            end
            StDone: begin
                ctrl.Done = 1'b1;
                if (!ctrl.Execute) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Count is the only datapath register; a reset aborts any run in progress.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Randomised bench for mult_seq_ctrl: the bench plays the register unit (shifting B to
// supply M) and predicts pulse counts and latencies from the multiplier operand alone.
`timescale 1ns/1ps
module tb_mult_seq_ctrl;
    localparam int W = 8;
`ifdef MULT_SEQ_SKIP_ADD_EN
    localparam bit SkipAdd = 1'b1;
`else
    localparam bit SkipAdd = 1'b0;
`endif

    logic Clk = 1'b0;
    logic Reset;
    int   checkCount = 0;
    int   passCount = 0;

    mult_seq_ctrl_if #(.WIDTH(W)) bus ();
    mult_seq_ctrl_if #(.WIDTH(1)) bus1 ();

    mult_seq_ctrl #(.WIDTH(W)) dut  (.Clk(Clk), .Reset(Reset), .ctrl(bus));
    mult_seq_ctrl #(.WIDTH(1)) dut1 (.Clk(Clk), .Reset(Reset), .ctrl(bus1));

    always #5 Clk = ~Clk;

    int         rBusy, rClr, rAdd, rSub, rShift, rDoneCycle, rDropCycle, rCountAtDone;
    int         rLdBad, rBothBad;
    logic [W-1:0] rAddMask;
    bit         rTimeout;

    // Runs one multiplication with Execute high for 'hold' sampled edges, recording observations.
    task automatic applyStimulus(input logic [W-1:0] bVal, input int hold);
        logic [W-1:0] bReg;
        int           c, shifts;
        bit           prevShift, doneSeen;
        bReg = bVal; shifts = 0; prevShift = 1'b0; doneSeen = 1'b0; c = 0;
        rBusy = 0; rClr = 0; rAdd = 0; rSub = 0; rShift = 0; rLdBad = 0; rBothBad = 0;
        rDoneCycle = -1; rDropCycle = -1; rCountAtDone = -1; rAddMask = '0; rTimeout = 1'b0;
        bus.M = bReg[0];
        bus.Execute = 1'b1;
        while (c < 300 && rDropCycle < 0) begin
            @(posedge Clk);
            if (prevShift) begin
                bReg = bReg >> 1;
                shifts++;
            end
            c++;
            #1;
            bus.Execute = (c < hold);
            bus.M = bReg[0];
            bus.LoadA = 1'($urandom_range(0, 1));
            bus.LoadB = 1'($urandom_range(0, 1));
            #1;
            if (bus.Busy) rBusy++;
            if ((bus.Busy || bus.Done) && (bus.Ld_A || bus.Ld_B)) rLdBad++;
            if (bus.Clr_XA) rClr++;
            if (bus.Add_En) begin
                rAdd++;
                if (shifts < W) rAddMask[shifts] = 1'b1;
            end
            if (bus.Sub_En) rSub++;
            if (bus.Add_En && bus.Sub_En) rBothBad++;
            if (bus.Shift_En) rShift++;
            if (bus.Done && !doneSeen) begin
                doneSeen = 1'b1;
                rDoneCycle = c;
                rCountAtDone = int'(bus.Count);
            end
            if (doneSeen && !bus.Done) rDropCycle = c;
            prevShift = bus.Shift_En;
        end
        if (rDropCycle < 0) rTimeout = 1'b1;
        bus.LoadA = 1'b0;
        bus.LoadB = 1'b0;
    endtask

    // Expected behaviour derived only from the operand bits and the Execute hold time.
    task automatic checkOutput(input logic [W-1:0] b, input int hold, input string name);
        int           expBusy, expAdd, expSub, expDone, expDrop;
        logic [W-1:0] expMask;
        expBusy = SkipAdd ? 1 + W + $countones(b) : 1 + 2 * W;
        expAdd  = $countones(b[W-2:0]);
        expSub  = int'(b[W-1]);
        expMask = {1'b0, b[W-2:0]};
        expDone = expBusy + 1;
        expDrop = ((hold > expDone) ? hold : expDone) + 1;
        applyStimulus(b, hold);
        checkCount++; if (rTimeout !== 1'b0) $display("[TB] FAIL %s timeout: no return to idle within 300 cycles", name); else passCount++;
        checkCount++; if (rBusy !== expBusy) $display("[TB] FAIL %s busy: got %0d want %0d", name, rBusy, expBusy); else passCount++;
        checkCount++; if (rClr !== 1) $display("[TB] FAIL %s clr pulses: got %0d want 1", name, rClr); else passCount++;
        checkCount++; if (rAdd !== expAdd) $display("[TB] FAIL %s add pulses: got %0d want %0d", name, rAdd, expAdd); else passCount++;
        checkCount++; if (rSub !== expSub) $display("[TB] FAIL %s sub pulses: got %0d want %0d", name, rSub, expSub); else passCount++;
        checkCount++; if (rShift !== W) $display("[TB] FAIL %s shift pulses: got %0d want %0d", name, rShift, W); else passCount++;
        checkCount++; if (rAddMask !== expMask) $display("[TB] FAIL %s add iterations: got %b want %b", name, rAddMask, expMask); else passCount++;
        checkCount++; if (rDoneCycle !== expDone) $display("[TB] FAIL %s done latency: got %0d want %0d", name, rDoneCycle, expDone); else passCount++;
        checkCount++; if (rDropCycle !== expDrop) $display("[TB] FAIL %s done release: got %0d want %0d", name, rDropCycle, expDrop); else passCount++;
        checkCount++; if (rCountAtDone !== W) $display("[TB] FAIL %s count at done: got %0d want %0d", name, rCountAtDone, W); else passCount++;
        checkCount++; if (rLdBad !== 0) $display("[TB] FAIL %s loads outside idle: got %0d want 0", name, rLdBad); else passCount++;
        checkCount++; if (rBothBad !== 0) $display("[TB] FAIL %s add and sub together: got %0d want 0", name, rBothBad); else passCount++;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.Execute = 1'b0; bus.M = 1'b0; bus.LoadA = 1'b1; bus.LoadB = 1'b0;
        bus1.Execute = 1'b0; bus1.M = 1'b0; bus1.LoadA = 1'b0; bus1.LoadB = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checkCount++; if (bus.Count !== 4'd0) $display("[TB] FAIL reset count: got %0d want 0", bus.Count); else passCount++;
        checkCount++; if (bus.Busy !== 1'b0) $display("[TB] FAIL reset busy: got %b want 0", bus.Busy); else passCount++;
        checkCount++; if (bus.Done !== 1'b0) $display("[TB] FAIL reset done: got %b want 0", bus.Done); else passCount++;
        checkCount++; if ({bus.Clr_XA, bus.Add_En, bus.Sub_En, bus.Shift_En} !== 4'b0) $display("[TB] FAIL reset enables: got %b want 0000", {bus.Clr_XA, bus.Add_En, bus.Sub_En, bus.Shift_En}); else passCount++;
        checkCount++; if ({bus.Ld_A, bus.Ld_B} !== 2'b10) $display("[TB] FAIL reset loads: got %b want 10", {bus.Ld_A, bus.Ld_B}); else passCount++;
        Reset = 1'b0;
        bus.LoadA = 1'b0;
    endtask

    task automatic test_idle_loads();
        logic la, lb;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            la = 1'($urandom_range(0, 1));
            lb = 1'(i[0]);
            bus.LoadA = la; bus.LoadB = lb;
            #1;
            checkCount++; if ({bus.Ld_A, bus.Ld_B} !== {la, lb}) $display("[TB] FAIL idle loads: got %b want %b", {bus.Ld_A, bus.Ld_B}, {la, lb}); else passCount++;
        end
        bus.LoadA = 1'b0; bus.LoadB = 1'b0;
    endtask

    task automatic test_directed();
        checkOutput(8'hB5, 1, "b5");
        checkOutput(8'h00, 1, "zero");
        checkOutput(8'hFF, 2, "ones");
        checkOutput(8'h80, 1, "signonly");
        checkOutput(8'h01, 3, "lsbonly");
    endtask

    task automatic test_held_execute();
        checkOutput(8'hB5, 30, "held");
    endtask

    task automatic test_random();
        logic [W-1:0] b;
        int           hold;
        for (int i = 0; i < 6; i++) begin
            b = W'($urandom);
            hold = $urandom_range(1, 24);
            checkOutput(b, hold, "random");
        end
    endtask

    task automatic test_reset_midrun();
        int busyN, c;
        busyN = 0; c = 0;
        bus.M = 1'b1;
        bus.Execute = 1'b1;
        while (busyN < 5 && c < 20) begin
            @(posedge Clk);
            c++;
            #1;
            bus.Execute = 1'b0;
            bus.M = 1'($urandom_range(0, 1));
            #1;
            if (bus.Busy) busyN++;
        end
        checkCount++; if (busyN !== 5) $display("[TB] FAIL midrun reach: got %0d busy cycles want 5", busyN); else passCount++;
        Reset = 1'b1;
        @(posedge Clk);
        #2;
        checkCount++; if (bus.Busy !== 1'b0) $display("[TB] FAIL midrun busy: got %b want 0", bus.Busy); else passCount++;
        checkCount++; if (bus.Count !== 4'd0) $display("[TB] FAIL midrun count: got %0d want 0", bus.Count); else passCount++;
        checkCount++; if ({bus.Clr_XA, bus.Add_En, bus.Sub_En, bus.Shift_En, bus.Done} !== 5'b0) $display("[TB] FAIL midrun enables: got %b want 00000", {bus.Clr_XA, bus.Add_En, bus.Sub_En, bus.Shift_En, bus.Done}); else passCount++;
        Reset = 1'b0;
        checkOutput(W'($urandom), 1, "restart");
    endtask

    task automatic test_width1();
        int busy, add, sub, shift, c, cnt;
        bit doneSeen;
        for (int m = 0; m < 2; m++) begin
            busy = 0; add = 0; sub = 0; shift = 0; c = 0; cnt = -1; doneSeen = 1'b0;
            bus1.M = 1'(m);
            bus1.Execute = 1'b1;
            while (!doneSeen && c < 20) begin
                @(posedge Clk);
                c++;
                #1;
                bus1.Execute = 1'b0;
                #1;
                if (bus1.Busy) busy++;
                if (bus1.Add_En) add++;
                if (bus1.Sub_En) sub++;
                if (bus1.Shift_En) shift++;
                if (bus1.Done) begin
                    doneSeen = 1'b1;
                    cnt = int'(bus1.Count);
                end
            end
            @(posedge Clk);
            #2;
            checkCount++; if (busy !== ((SkipAdd && m == 0) ? 2 : 3)) $display("[TB] FAIL w1 busy m=%0d: got %0d want %0d", m, busy, (SkipAdd && m == 0) ? 2 : 3); else passCount++;
            checkCount++; if (sub !== m) $display("[TB] FAIL w1 sub m=%0d: got %0d want %0d", m, sub, m); else passCount++;
            checkCount++; if (add !== 0) $display("[TB] FAIL w1 add m=%0d: got %0d want 0", m, add); else passCount++;
            checkCount++; if (shift !== 1) $display("[TB] FAIL w1 shift m=%0d: got %0d want 1", m, shift); else passCount++;
            checkCount++; if (cnt !== 1) $display("[TB] FAIL w1 count m=%0d: got %0d want 1", m, cnt); else passCount++;
            checkCount++; if (bus1.Done !== 1'b0) $display("[TB] FAIL w1 release m=%0d: got %b want 0", m, bus1.Done); else passCount++;
        end
    endtask

    initial begin
        test_reset();
        test_idle_loads();
        test_directed();
        test_held_execute();
        test_random();
        test_reset_midrun();
        test_width1();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Parametrised sequencing controller for the add-shift signed multiplier datapath. It replaces the fixed-length shift-only controller with a WIDTH-iteration add/shift/subtract sequence. Per iteration it inspects the multiplier LSB M and drives clear, add, subtract and shift enables to the accumulator/register unit. It sits between the switch/button synchronisers and the register unit plus adder.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (= iterations); legal range 1..32
- CW, $clog2(WIDTH+1), width of Count output (derived, not overridden)

Ports:
- Clk  in  1  clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high
- LoadA  in  1  load-A request (honoured only in IDLE)
- LoadB  in  1  load-B request (honoured only in IDLE)
- Execute  in  1  run request, level-sensitive, pre-synchronised
- M  in  1  current multiplier LSB from register B
- Ld_A  out  1  load A
- Ld_B  out  1  load B
- Clr_XA  out  1  clear X flag and accumulator A
- Add_En  out  1  A <= A + S
- Sub_En  out  1  A <= A - S (sign iteration)
- Shift_En  out  1  arithmetic right shift of X:A:B
- Busy  out  1  sequence in progress
- Done  out  1  result valid, held until Execute released
- Count  out  CW  shifts completed in current run

## Operation
- States: IDLE, CLR, ADD, SHIFT, DONE. All outputs are combinational from state, Count and inputs. Count is the only datapath register.
- IDLE:
  - Ld_A = LoadA, Ld_B = LoadB; all other enables 0; Busy = Done = 0.
  - Execute = 1 -> CLR.
- CLR:
  - Clr_XA = 1, Count <= 0, Busy = 1.
  - -> ADD.
- ADD (iteration i = Count), Busy = 1:
  - i < WIDTH-1: Add_En = M.
  - i = WIDTH-1: Sub_En = M.
  - -> SHIFT.
  - Add_En and Sub_En are never both 1.
- SHIFT:
  - Shift_En = 1, Count <= Count + 1, Busy = 1.
  - If Count+1 = WIDTH -> DONE, else -> ADD.
- DONE:
  - Done = 1, all enables 0, Count holds WIDTH.
  - Execute = 0 -> IDLE; otherwise stay.
- LoadA/LoadB are ignored in every state except IDLE.
- Execute is ignored in CLR/ADD/SHIFT; dropping it mid-run does not abort.
- Holding Execute high through DONE never retriggers. A new run needs Execute low for at least 1 cycle.
- WIDTH = 1: the single iteration is the sign iteration (Sub_En = M, never Add_En).
- Count never exceeds WIDTH and never wraps.

## Timing
- Reset is synchronous. After any edge with Reset = 1: state = IDLE, Count = 0, Busy = Done = Clr_XA = Add_En = Sub_En = Shift_En = 0, and Ld_A/Ld_B follow LoadA/LoadB.
- Reset mid-run aborts the run at that edge; no further enables are issued.
- Execute sampled high in IDLE at edge k:
  - CLR occupies cycle k+1.
  - ADD/SHIFT pairs follow.
  - Macro off: Busy high for exactly 1 + 2*WIDTH cycles; Done first high 2 + 2*WIDTH cycles after edge k.
- Execute sampled low in DONE at edge j: IDLE in cycle j+1, Done = 0.
- M is sampled combinationally in ADD. The register unit must present the post-shift LSB in the cycle following a SHIFT.
- Exactly WIDTH Shift_En pulses and exactly 1 Clr_XA pulse per run, each 1 cycle wide.

## Configuration
- MULT_SEQ_SKIP_ADD_EN undefined:
  - Fixed latency. ADD always takes a cycle; with M = 0 that cycle issues no enable.
- MULT_SEQ_SKIP_ADD_EN defined:
  - In ADD with M = 0, the cycle acts as SHIFT (Shift_En = 1, Count increments, same DONE check) and stays in ADD when not finished.
  - With M = 1, behaviour is unchanged.
  - Busy length = 1 + WIDTH + (number of 1 bits among the M values seen).
  - Pulse counts of Add_En, Sub_En, Shift_En and Clr_XA are identical to macro-off.

## Test plan
- WIDTH=8, macro off, M stream = bits of B=8'hB5 LSB first, Execute pulsed: Busy 17 cycles; Clr_XA 1, Add_En 4, Sub_En 1, Shift_En 8 pulses; Count = 8 in DONE.
- Same run, macro on: Busy 14 cycles; identical pulse counts; Done 15 cycles after Execute edge.
- B=8'h00, macro on: Busy 9 cycles, no Add_En/Sub_En. Macro off: Busy 17 cycles.
- Execute held high 30 cycles: single run; Done stays 1 until Execute low; IDLE (Done = 0) exactly 1 cycle after Execute sampled low; no second Clr_XA.
- Reset asserted in the 5th Busy cycle: next cycle IDLE, Count = 0, all enables 0; a fresh Execute restarts with Clr_XA.
- LoadA = LoadB = 1 during Busy: Ld_A = Ld_B = 0. In IDLE they mirror inputs the same cycle. WIDTH=1, M=1: one Sub_En, one Shift_En, Busy 3 cycles.
